// File: rtl/sc_seq_pkg.sv
// Shared types and constants for the switched-capacitor phase sequencer.
package sc_seq_pkg;

   localparam int DEF_CNT_W = 8;
   localparam int MIN_LEN   = 1;

   typedef enum logic [2:0] {
      IDLE,
      PH1,
      NOV12,
      PH2,
      NOV21
   } state_t;

   // A programmed length of zero still has to dwell one cycle, so the dead
   // time can never collapse and phi1/phi2 can never touch.
   function automatic logic [DEF_CNT_W-1:0] sat_len(input logic [DEF_CNT_W-1:0] len);
      return (len == '0) ? DEF_CNT_W'(MIN_LEN) : len;
   endfunction

endpackage

// File: rtl/sc_dwell_counter.sv
// Loadable dwell down-counter. A load sets the dwell length, with zero
// clamped to one. The counter stops at zero and never wraps. last is high
// on the final cycle of a dwell, and last_nxt is the value last takes after
// the coming edge.
module sc_dwell_counter
   import sc_seq_pkg::*;
#(
   parameter int W = DEF_CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         last,
   output logic         last_nxt
);

   logic [W-1:0] cnt;
   logic [W-1:0] cnt_d;

   // next count: reload on state entry, otherwise count down to zero and stop
   always_comb begin
      cnt_d = cnt;
      if (load) begin
         cnt_d = sat_len(load_val);
      end else if (cnt != '0) begin
         cnt_d = cnt - W'(1);
      end
   end

   assign last_nxt = (cnt_d == W'(MIN_LEN));

   // count register and registered last-cycle flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         last <= 1'b0;
      end else begin
         cnt  <= cnt_d;
         last <= last_nxt;
      end
   end

endmodule

// File: rtl/sc_phase_sequencer.sv
// Non-overlapping phi1/phi2 sequencer for the SC filter and its SC CMFB.
// Optional macro SC_PHASE_EARLY_EN adds the bottom-plate early phases
// phi1e/phi2e. These rise with their phase and fall one cycle earlier.
//
//   state | meaning
//   IDLE  | both phases low, config accepted, waiting for en
//   PH1   | phi1 high: input switches and CMFB sample
//   NOV12 | dead time between phi1 and phi2
//   PH2   | phi2 high: integration and CMFB refresh
//   NOV21 | dead time after phi2; the last cycle flags period_done
//
// Every output is a flop loaded from the next state, so the switches never
// see a decode glitch.
module sc_phase_sequencer
   import sc_seq_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int RST_PH1_LEN = 4,
   parameter int RST_PH2_LEN = 4,
   parameter int RST_NOV_LEN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W-1:0] cfg_ph1_len,
   input  logic [CNT_W-1:0] cfg_ph2_len,
   input  logic [CNT_W-1:0] cfg_nov_len,
   output logic             phi1,
   output logic             phi2,
   output logic             period_done,
   output logic             busy
`ifdef SC_PHASE_EARLY_EN
   ,
   output logic             phi1e,
   output logic             phi2e
`endif
);

   state_t           state, state_d;
   logic             load;
   logic [CNT_W-1:0] load_val;
   logic             last, last_nxt;
   logic             xfer;
   logic [CNT_W-1:0] ph1_act, ph2_act, nov_act;
   logic [CNT_W-1:0] ph1_src;

   // The config can arrive on the same edge that enters PH1, so that PH1
   // uses the offered length directly. Later phases read the updated active
   // registers.
   assign xfer    = cfg_valid & cfg_ready;
   assign ph1_src = xfer ? cfg_ph1_len : ph1_act;

   sc_dwell_counter #(.W(CNT_W)) u_dwell (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .last     (last),
      .last_nxt (last_nxt)
   );

   // next state and counter reload on each phase entry
   always_comb begin
      state_d  = state;
      load     = 1'b0;
      load_val = ph1_src;
      unique case (state)
         IDLE: begin
            if (en) begin
               state_d  = PH1;
               load     = 1'b1;
               load_val = ph1_src;
            end
         end
         PH1: begin
            if (last) begin
               state_d  = NOV12;
               load     = 1'b1;
               load_val = nov_act;
            end
         end
         NOV12: begin
            if (last) begin
               state_d  = PH2;
               load     = 1'b1;
               load_val = ph2_act;
            end
         end
         PH2: begin
            if (last) begin
               state_d  = NOV21;
               load     = 1'b1;
               load_val = nov_act;
            end
         end
         NOV21: begin
            if (last) begin
               if (en) begin
                  state_d  = PH1;
                  load     = 1'b1;
                  load_val = ph1_src;
               end else begin
                  state_d  = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state, registered outputs and active configuration
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         phi1        <= 1'b0;
         phi2        <= 1'b0;
         period_done <= 1'b0;
         busy        <= 1'b0;
         cfg_ready   <= 1'b1;
         ph1_act     <= CNT_W'(RST_PH1_LEN);
         ph2_act     <= CNT_W'(RST_PH2_LEN);
         nov_act     <= CNT_W'(RST_NOV_LEN);
      end else begin
         state       <= state_d;
         phi1        <= (state_d == PH1);
         phi2        <= (state_d == PH2);
         period_done <= (state_d == NOV21) && last_nxt;
         busy        <= (state_d != IDLE);
         cfg_ready   <= (state_d == IDLE) || ((state_d == NOV21) && last_nxt);
         if (xfer) begin
            ph1_act <= cfg_ph1_len;
            ph2_act <= cfg_ph2_len;
            nov_act <= cfg_nov_len;
         end
      end
   end

`ifdef SC_PHASE_EARLY_EN
   // Early phases drop on the final dwell cycle. The entry cycle always
   // keeps them high, so a one-cycle phase gives phiNe equal to phiN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phi1e <= 1'b0;
         phi2e <= 1'b0;
      end else begin
         phi1e <= (state_d == PH1) && (!last_nxt || (state != PH1));
         phi2e <= (state_d == PH2) && (!last_nxt || (state != PH2));
      end
   end
`endif

endmodule
